// File: rtl/game_pkg.sv
// Shared constants and FSM state type for the box collision scheduler.
// Screen extent bounds the 10-bit X / 9-bit Y position fields.
package game_pkg;

  localparam int N        = 4;
  localparam int BOX_W    = 48;
  localparam int BOX_H    = 32;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int P        = N * (N - 1) / 2;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned overlap test for two equal-size boxes.
// Sums are widened by one bit so edge boxes never wrap.
module box_overlap #(
  parameter int BOX_W = 48,
  parameter int BOX_H = 32
) (
  input  logic [9:0] ax,
  input  logic [9:0] bx,
  input  logic [8:0] ay,
  input  logic [8:0] by,
  output logic       ov
);

  logic [10:0] ax_e;
  logic [10:0] bx_e;
  logic [9:0]  ay_e;
  logic [9:0]  by_e;

  assign ax_e = {1'b0, ax} + 11'(BOX_W);
  assign bx_e = {1'b0, bx} + 11'(BOX_W);
  assign ay_e = {1'b0, ay} + 10'(BOX_H);
  assign by_e = {1'b0, by} + 10'(BOX_H);

  // strict compares: shared edges do not count as overlap
  assign ov = ({1'b0, ax} < bx_e) && ({1'b0, bx} < ax_e) &&
              ({1'b0, ay} < by_e) && ({1'b0, by} < ay_e);

endmodule

// File: rtl/collision_sched.sv
// Per-frame pairwise box collision scan, one pair per cycle,
// reporting only newly started overlaps over a valid/ready port.
module collision_sched #(
  parameter int N     = game_pkg::N,
  parameter int BOX_W = game_pkg::BOX_W,
  parameter int BOX_H = game_pkg::BOX_H
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 frame_tick,
  input  logic [N*10-1:0]      posx_flat,
  input  logic [N*9-1:0]       posy_flat,
  output logic                 hit_valid,
  output logic [$clog2(N)-1:0] hit_a,
  output logic [$clog2(N)-1:0] hit_b,
  input  logic                 hit_ready,
  output logic                 busy,
  output logic                 scan_done,
  output logic [7:0]           overrun_cnt
);

  localparam int AW    = $clog2(N);
  localparam int NPAIR = N * (N - 1) / 2;
  localparam int PW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;

  import game_pkg::*;

  state_t state, state_nx;

  logic [N*10-1:0]  snap_x;
  logic [N*9-1:0]   snap_y;
  logic [NPAIR-1:0] prev_ov;
  logic [AW-1:0]    pa, pb, pa_nx, pb_nx;
  logic [AW-1:0]    pa_adv, pb_adv;
  logic [AW-1:0]    ha, hb, ha_nx, hb_nx;
  logic [PW-1:0]    pidx, pidx_nx;
  logic [7:0]       ovr;
  logic             snap, chk, ov, last;
  logic [9:0]       ax, bx;
  logic [8:0]       ay, by;

  assign ax = snap_x[int'(pa)*10 +: 10];
  assign bx = snap_x[int'(pb)*10 +: 10];
  assign ay = snap_y[int'(pa)*9 +: 9];
  assign by = snap_y[int'(pb)*9 +: 9];

  box_overlap #(
    .BOX_W(BOX_W),
    .BOX_H(BOX_H)
  ) u_ov (
    .ax(ax),
    .bx(bx),
    .ay(ay),
    .by(by),
    .ov(ov)
  );

  assign last = (pidx == PW'(NPAIR - 1));

  // next pair in (0,1),(0,2)..(N-2,N-1) order
  always_comb begin
    pa_adv = pa;
    pb_adv = pb + AW'(1);
    if (pb == AW'(N - 1)) begin
      pa_adv = pa + AW'(1);
      pb_adv = pa + AW'(2);
    end
  end

  always_comb begin
    state_nx = state;
    pa_nx    = pa;
    pb_nx    = pb;
    pidx_nx  = pidx;
    ha_nx    = ha;
    hb_nx    = hb;
    snap     = 1'b0;
    chk      = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && frame_tick) begin
          state_nx = CHECK;
          pa_nx    = '0;
          pb_nx    = AW'(1);
          pidx_nx  = '0;
          snap     = 1'b1;
        end
      end
      CHECK: begin
        chk = 1'b1;
        if (ov && !prev_ov[pidx]) begin
          state_nx = EMIT;
          ha_nx    = pa;
          hb_nx    = pb;
        end else if (last) begin
          state_nx = DONE;
        end else begin
          pa_nx   = pa_adv;
          pb_nx   = pb_adv;
          pidx_nx = pidx + PW'(1);
        end
      end
      EMIT: begin
        if (hit_ready) begin
          if (last) begin
            state_nx = DONE;
          end else begin
            state_nx = CHECK;
            pa_nx    = pa_adv;
            pb_nx    = pb_adv;
            pidx_nx  = pidx + PW'(1);
          end
        end
      end
      DONE: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      snap_x  <= '0;
      snap_y  <= '0;
      prev_ov <= '0;
      pa      <= '0;
      pb      <= '0;
      pidx    <= '0;
      ha      <= '0;
      hb      <= '0;
      ovr     <= '0;
    end else begin
      state <= state_nx;
      pa    <= pa_nx;
      pb    <= pb_nx;
      pidx  <= pidx_nx;
      ha    <= ha_nx;
      hb    <= hb_nx;
      if (snap) begin
        snap_x <= posx_flat;
        snap_y <= posy_flat;
      end
      if (chk) prev_ov[pidx] <= ov;
      if (state != IDLE && enable && frame_tick && ovr != 8'hFF)
        ovr <= ovr + 8'd1;
    end
  end

  assign hit_valid   = (state == EMIT);
  assign hit_a       = ha;
  assign hit_b       = hb;
  assign busy        = (state != IDLE);
  assign scan_done   = (state == DONE);
  assign overrun_cnt = ovr;

endmodule

// File: tb/tb_collision_sched.sv
// Directed vector bench for collision_sched (N=4, 48x32 boxes).
// Events are encoded one nibble {a,b} per event, first event lowest.
module tb_collision_sched;

  logic        clk = 1'b0;
  logic        rst, enable, frame_tick, hit_ready;
  logic [39:0] posx_flat;
  logic [35:0] posy_flat;
  logic        hit_valid, busy, scan_done;
  logic [1:0]  hit_a, hit_b;
  logic [7:0]  overrun_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  collision_sched dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .frame_tick(frame_tick),
    .posx_flat(posx_flat),
    .posy_flat(posy_flat),
    .hit_valid(hit_valid),
    .hit_a(hit_a),
    .hit_b(hit_b),
    .hit_ready(hit_ready),
    .busy(busy),
    .scan_done(scan_done),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] px;
    logic [35:0] py;
    int          n;
    logic [23:0] ev;
  } vec_t;

  vec_t vt[12];

  function automatic logic [39:0] px4(int x0, int x1, int x2, int x3);
    return {10'(x3), 10'(x2), 10'(x1), 10'(x0)};
  endfunction

  function automatic logic [35:0] py4(int y0, int y1, int y2, int y3);
    return {9'(y3), 9'(y2), 9'(y1), 9'(y0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    frame_tick = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic collect(output int n, output logic [23:0] ev,
                         output bit to);
    n  = 0;
    ev = '0;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (hit_valid) begin
        if (n < 6) ev[n*4 +: 4] = {hit_a, hit_b};
        n++;
      end
      if (scan_done) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (hit_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n, nb, sd, nsd;
    logic [23:0] ev;
    bit          to, found;
    logic [39:0] spx;
    logic [35:0] spy;

    spx = px4(20, 80, 140, 200);
    spy = py4(20, 60, 100, 140);

    vt[0]  = '{spx, spy, 0, 24'h0};
    vt[1]  = '{px4(100, 400, 120, 500), py4(100, 300, 110, 400), 1, 24'h2};
    vt[2]  = '{px4(100, 400, 120, 500), py4(100, 300, 110, 400), 0, 24'h0};
    vt[3]  = '{px4(0, 48, 300, 500), py4(0, 0, 200, 400), 0, 24'h0};
    vt[4]  = '{px4(0, 47, 300, 500), py4(0, 0, 200, 400), 1, 24'h1};
    vt[5]  = '{px4(200, 200, 200, 200), py4(200, 200, 200, 200),
               5, 24'h0B7632};
    vt[6]  = '{spx, spy, 0, 24'h0};
    vt[7]  = '{px4(200, 200, 200, 200), py4(200, 200, 200, 200),
               6, 24'hB76321};
    vt[8]  = '{px4(0, 0, 300, 500), py4(0, 32, 200, 400), 0, 24'h0};
    vt[9]  = '{px4(0, 0, 300, 500), py4(0, 31, 200, 400), 1, 24'h1};
    vt[10] = '{spx, spy, 0, 24'h0};
    vt[11] = '{px4(1000, 990, 300, 300), py4(0, 10, 500, 490),
               2, 24'hB1};

    rst        = 1'b1;
    enable     = 1'b1;
    frame_tick = 1'b0;
    hit_ready  = 1'b1;
    posx_flat  = '0;
    posy_flat  = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {18'd0, hit_valid, busy, scan_done, hit_a, hit_b, overrun_cnt},
          32'd0);
    rst = 1'b0;

    // no-event latency and busy width
    posx_flat = spx;
    posy_flat = spy;
    @(negedge clk);
    tick();
    nb  = 0;
    sd  = 0;
    nsd = 0;
    for (int i = 1; i <= 20; i++) begin
      if (busy) nb++;
      if (scan_done) begin
        nsd++;
        if (sd == 0) sd = i;
      end
      @(negedge clk);
    end
    check("latency_scan_done", 32'(sd), 32'd7);
    check("latency_busy_cycles", 32'(nb), 32'd7);
    check("scan_done_width", 32'(nsd), 32'd1);

    for (int v = 0; v < 12; v++) begin
      posx_flat = vt[v].px;
      posy_flat = vt[v].py;
      @(negedge clk);
      tick();
      collect(n, ev, to);
      check($sformatf("vec%0d_timeout", v), 32'(to), 32'd0);
      check($sformatf("vec%0d_count", v), 32'(n), 32'(vt[v].n));
      check($sformatf("vec%0d_events", v), 32'(ev), 32'(vt[v].ev));
      @(negedge clk);
    end

    // backpressure: 0,1,3 overlap, box2 far
    do_reset();
    posx_flat = px4(100, 110, 400, 120);
    posy_flat = py4(100, 110, 400, 105);
    hit_ready = 1'b0;
    tick();
    wait_valid("stall_first_valid");
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_valid_%0d", k), 32'(hit_valid), 32'd1);
      check($sformatf("stall_pair_%0d", k), 32'({hit_a, hit_b}), 32'h1);
      @(negedge clk);
    end
    hit_ready = 1'b1;
    collect(n, ev, to);
    check("stall_timeout", 32'(to), 32'd0);
    check("stall_count", 32'(n), 32'd3);
    check("stall_events", 32'(ev), 32'h731);
    @(negedge clk);

    // overrun counting and enable gating
    do_reset();
    posx_flat = spx;
    posy_flat = spy;
    enable    = 1'b0;
    tick();
    check("enable_low_idle", 32'(busy), 32'd0);
    enable = 1'b1;
    tick();
    frame_tick = 1'b1;
    repeat (3) @(negedge clk);
    frame_tick = 1'b0;
    enable     = 1'b0;
    tick();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (scan_done) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("enable_drop_no_abort", 32'(found), 32'd1);
    check("overrun_three", 32'(overrun_cnt), 32'd3);
    @(negedge clk);
    enable     = 1'b1;
    frame_tick = 1'b1;
    repeat (400) @(negedge clk);
    frame_tick = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("overrun_idle", 32'(found), 32'd1);
    check("overrun_saturate", 32'(overrun_cnt), 32'd255);

    // reset while an event is pending
    do_reset();
    posx_flat = px4(100, 400, 120, 500);
    posy_flat = py4(100, 300, 110, 400);
    hit_ready = 1'b0;
    tick();
    wait_valid("rst_emit_valid");
    check("rst_emit_pair", 32'({hit_a, hit_b}), 32'h2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_emit_outputs",
          {18'd0, hit_valid, busy, scan_done, hit_a, hit_b, overrun_cnt},
          32'd0);
    rst       = 1'b0;
    hit_ready = 1'b1;
    tick();
    collect(n, ev, to);
    check("rst_rereport_timeout", 32'(to), 32'd0);
    check("rst_rereport_count", 32'(n), 32'd1);
    check("rst_rereport_events", 32'(ev), 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_sched.md
COLLISION_SCHED -- requirements
Module: collision_sched

Interface
REQ-001 Parameter N, default 4: number of boxes; pair count P = N*(N-1)/2.
REQ-002 Parameter BOX_W, default 48: box width, pixels.
REQ-003 Parameter BOX_H, default 32: box height, pixels.
REQ-004 clk  in  1  single clock, all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  when low, frame_tick ignored (no scan, no overrun count).
REQ-007 frame_tick  in  1  one-cycle pulse starting a scan.
REQ-008 posx_flat  in  N*10  box i X at [i*10 +: 10].
REQ-009 posy_flat  in  N*9  box i Y at [i*9 +: 9].
REQ-010 hit_valid  out  1  new-collision event pending.
REQ-011 hit_a  out  clog2(N)  lower box index of event.
REQ-012 hit_b  out  clog2(N)  higher box index of event.
REQ-013 hit_ready  in  1  consumer accepts event when high with hit_valid.
REQ-014 busy  out  1  scan in progress (any state except IDLE).
REQ-015 scan_done  out  1  one-cycle pulse at scan end.
REQ-016 overrun_cnt  out  8  ticks dropped while busy, saturating.

Function
REQ-017 FSM states: IDLE, CHECK, EMIT, DONE.
REQ-018 IDLE: enable && frame_tick sampled -> snapshot posx_flat/posy_flat into internal registers, pair index to (0,1), go CHECK.
REQ-019 All checks use the snapshot only; input changes during a scan have no effect.
REQ-020 CHECK: evaluate one pair (a,b) per cycle, order (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1).
REQ-021 Overlap = ax < bx+BOX_W && bx < ax+BOX_W && ay < by+BOX_H && by < ay+BOX_H; sums computed 11-bit (X) / 10-bit (Y), no wrap; touching edges is not overlap.
REQ-022 Per-pair register prev_ov[P]; each CHECK cycle writes prev_ov[pair] <= overlap.
REQ-023 overlap && !prev_ov[pair] -> load hit_a=a, hit_b=b, go EMIT; otherwise advance pair.
REQ-024 EMIT: hit_valid high; hit_a/hit_b stable until hit_valid && hit_ready sampled, then advance pair (or DONE if last) next cycle.
REQ-025 hit_valid never high outside EMIT; at most one event per pair per scan.
REQ-026 After last pair (check or accepted emit), go DONE; DONE drives scan_done high one cycle, then IDLE.
REQ-027 No-event latency: tick sampled at edge E0 -> scan_done high in the cycle following edge E0+P (P=6 for N=4); busy high E0 through DONE.
REQ-028 frame_tick && enable sampled in any state except IDLE -> overrun_cnt +1, saturate at 255; tick otherwise dropped.
REQ-029 frame_tick coinciding with scan_done (DONE state) counts as overrun.
REQ-030 enable deassertion mid-scan does not abort the scan.

Reset
REQ-031 rst sampled high: state IDLE, hit_valid 0, hit_a/hit_b 0, busy 0, scan_done 0, overrun_cnt 0, prev_ov all 0, snapshot 0.
REQ-032 rst mid-scan or mid-EMIT aborts immediately; pending event discarded, no scan_done.

Structure
REQ-033 Shared package game_pkg holds N, BOX_W, BOX_H, SCREEN_W, SCREEN_H, P, and the FSM state enum.
REQ-034 Overlap comparator is sub-module box_overlap (combinational, one instance, pair-muxed inputs).

Verification
REQ-035 Boxes at (20,20),(80,60),(140,100),(200,140), tick -> no hit_valid; scan_done 6 cycles after sampling edge; busy high 7 cycles.
REQ-036 Box0 (100,100), box2 (120,110), others far; tick with hit_ready=1 -> one event a=0,b=2; second tick same positions -> no event.
REQ-037 Box0 (0,0), box1 (48,0) touching -> no event; box1 moved to (47,0), tick -> event (0,1).
REQ-038 Boxes 0,1,3 mutually overlapping, hit_ready held low 5 cycles -> hit_valid/(0,1) stable; then events (0,1),(0,3),(1,3) in order; scan_done after last.
REQ-039 Three ticks during one scan -> overrun_cnt=3; 300 such ticks -> overrun_cnt=255.
REQ-040 rst asserted during EMIT -> next cycle all outputs at reset values; following tick with same overlapping positions re-reports event (prev_ov cleared).
